fp_add_seq: RTL and testbench

FP_ADD_SEQ -- requirements
Module: fp_add_seq

---
 rtl/fp_add_seq.sv | 216 +++++++++++++++++++++
 tb/tb_fp_add_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_seq.sv
// Sequential floating-point adder: IDLE -> ALIGN -> ADD -> NORM -> DONE, truncating, saturating.
// Optional overflow flag output when FP_ADD_SEQ_OVF_EN is defined.
module fp_add_seq #(
  parameter int unsigned EXP_W = 4,
  parameter int unsigned MAN_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef FP_ADD_SEQ_OVF_EN
  output logic                   ovf,
`endif
  output logic [EXP_W+MAN_W:0]   sum
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned RES_W = MAN_W + 2;
  localparam int unsigned ADD_W = MAN_W + 3;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_SAT  = EXP_ONES - EXP_W'(1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_e;

  state_e             state_q, state_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [EXP_W-1:0]   exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [SIG_W-1:0]   sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [EXP_W-1:0]   res_exp_q, res_exp_d;
  logic               res_sign_q, res_sign_d;
  logic               zero_q, zero_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  // Magnitude-ordered operands feed a single signed adder; the result is never negative.
  logic                    a_ge_b_c;
  logic [SIG_W-1:0]        big_c, small_c;
  logic signed [ADD_W-1:0] add_x_c, add_y_c, add_s_c;
  logic                    sat_c;

  assign a_ge_b_c = (sig_a_q >= sig_b_q);
  assign big_c    = a_ge_b_c ? sig_a_q : sig_b_q;
  assign small_c  = a_ge_b_c ? sig_b_q : sig_a_q;
  assign add_x_c  = $signed({2'b00, big_c});
  assign add_y_c  = (sign_a_q == sign_b_q) ? $signed({2'b00, small_c})
                                           : -$signed({2'b00, small_c});
  assign add_s_c  = add_x_c + add_y_c;
  assign sat_c    = !zero_q && (res_exp_q == EXP_ONES);

  always_comb begin
    state_d     = state_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    sig_a_d     = sig_a_q;
    sig_b_d     = sig_b_q;
    res_d       = res_q;
    res_exp_d   = res_exp_q;
    res_sign_d  = res_sign_q;
    zero_d      = zero_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_a_d = a[W-1];
          exp_a_d  = a[W-2:MAN_W];
          sig_a_d  = (a[W-2:MAN_W] == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
          sign_b_d = b[W-1];
          exp_b_d  = b[W-2:MAN_W];
          sig_b_d  = (b[W-2:MAN_W] == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
          zero_d   = 1'b0;
          state_d  = ALIGN;
        end
      end

      ALIGN: begin
        if (exp_a_q < exp_b_q) begin
          if (32'(exp_b_q - exp_a_q) > MAN_W + 1) begin
            sig_a_d = '0;
            exp_a_d = exp_b_q;
          end else begin
            sig_a_d = sig_a_q >> 1;
            exp_a_d = exp_a_q + EXP_W'(1);
          end
        end else if (exp_b_q < exp_a_q) begin
          if (32'(exp_a_q - exp_b_q) > MAN_W + 1) begin
            sig_b_d = '0;
            exp_b_d = exp_a_q;
          end else begin
            sig_b_d = sig_b_q >> 1;
            exp_b_d = exp_b_q + EXP_W'(1);
          end
        end else begin
          state_d = ADD;
        end
      end

      ADD: begin
        res_d      = add_s_c[ADD_W-1] ? '0 : add_s_c[RES_W-1:0];
        res_exp_d  = exp_a_q;
        res_sign_d = (sign_a_q == sign_b_q) ? sign_a_q
                                            : (a_ge_b_c ? sign_a_q : sign_b_q);
        state_d    = NORM;
      end

      // One normalisation step per cycle; a carry shift re-enters NORM to settle.
      NORM: begin
        if (res_q[RES_W-1]) begin
          res_d     = res_q >> 1;
          res_exp_d = res_exp_q + EXP_W'(1);
        end else if (res_q == '0) begin
          zero_d     = 1'b1;
          res_sign_d = 1'b0;
          state_d    = DONE;
        end else if (!res_q[MAN_W]) begin
          res_d     = res_q << 1;
          res_exp_d = res_exp_q - EXP_W'(1);
          if (res_exp_q == EXP_W'(1)) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (!out_valid_q) begin
          if (zero_q) begin
            sum_d = {res_sign_q, {(W-1){1'b0}}};
          end else if (sat_c) begin
            sum_d = {res_sign_q, EXP_SAT, {MAN_W{1'b1}}};
          end else begin
            sum_d = {res_sign_q, res_exp_q, res_q[MAN_W-1:0]};
          end
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      sig_a_q     <= '0;
      sig_b_q     <= '0;
      res_q       <= '0;
      res_exp_q   <= '0;
      res_sign_q  <= 1'b0;
      zero_q      <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      sig_a_q     <= sig_a_d;
      sig_b_q     <= sig_b_d;
      res_q       <= res_d;
      res_exp_q   <= res_exp_d;
      res_sign_q  <= res_sign_d;
      zero_q      <= zero_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

`ifdef FP_ADD_SEQ_OVF_EN
  logic ovf_q;

  // Flag captured alongside the packed result and cleared when it is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == DONE) begin
      if (!out_valid_q) begin
        ovf_q <= sat_c;
      end else if (out_ready) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed scoreboard bench for fp_add_seq (EXP_W=4, MAN_W=3), hand-computed expectations.
module tb_fp_add_seq;
  localparam int unsigned EXP_W = 4;
  localparam int unsigned MAN_W = 3;
  localparam int unsigned W     = 1 + EXP_W + MAN_W;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
`ifdef FP_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] sum;
    int           lat;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  fp_add_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FP_ADD_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Push the expected result, present operands and pass the accept edge.
  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] s, input int lat, input logic o);
    exp_t e;
    e.sum = s;
    e.lat = lat;
    e.ovf = o;
    sb.push_back(e);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  // Wait (bounded) for out_valid, then pop and compare against the scoreboard.
  task automatic collect(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e.sum));
      if (e.lat >= 0) check({tag, "_latency"}, 32'(n), 32'(e.lat));
`ifdef FP_ADD_SEQ_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    end
  endtask

  task automatic handshake(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 8'h38;
    b         = 8'h38;
    out_ready = 1'b1;

    // Reset state before any clock edge, then with operands offered during reset.
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ignore_in_ready", 32'(in_ready), 32'd1);
    check("rst_ignore_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1.0 + 1.0: carry normalisation.
    drive(8'h38, 8'h38, 8'h40, 5, 1'b0);
    collect("one_plus_one");
    handshake("one_plus_one");

    // 1.0 + 0.25: two alignment cycles.
    drive(8'h38, 8'h28, 8'h3A, 6, 1'b0);
    collect("one_plus_quarter");
    handshake("one_plus_quarter");

    // 1.5 - 1.5: exact cancellation gives +0.
    drive(8'h3C, 8'hBC, 8'h00, 4, 1'b0);
    collect("cancel");
    handshake("cancel");

    // Max finite + max finite: saturates.
    drive(8'h77, 8'h77, 8'h77, 5, 1'b1);
    collect("saturate");
    handshake("saturate");

    // 0.25 - 1.0 = -0.75: two alignments, one left shift, sign of larger.
    drive(8'h28, 8'hB8, 8'hB4, 7, 1'b0);
    collect("neg_larger");
    handshake("neg_larger");

    // Large exponent gap zeroes the small operand in one cycle.
    drive(8'h60, 8'h08, 8'h60, 5, 1'b0);
    collect("far_align");
    handshake("far_align");

    // Exponent-0 operand is zero regardless of its mantissa.
    drive(8'h05, 8'h38, 8'h38, 5, 1'b0);
    collect("zero_operand");
    handshake("zero_operand");

    // -1.0 + -1.0 = -2.0.
    drive(8'hB8, 8'hB8, 8'hC0, 5, 1'b0);
    collect("neg_carry");
    handshake("neg_carry");

    // Underflow during left normalisation flushes to signed zero.
    drive(8'h8C, 8'h08, 8'h80, -1, 1'b0);
    collect("flush");
    handshake("flush");

    // Backpressure: 1.5 - 1.0 = 0.5 held for 5 cycles.
    out_ready = 1'b0;
    drive(8'h3C, 8'hB8, 8'h30, 5, 1'b0);
    collect("hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'h30);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    handshake("hold_release");

    // Reset during ALIGN discards the operation.
    drive(8'h38, 8'h28, 8'h3A, 6, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sum", 32'(sum), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    drive(8'h38, 8'h38, 8'h40, 5, 1'b0);
    collect("after_rst");
    handshake("after_rst");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
